// File: rtl/ex_result_skid_if.sv
// ----------------------------------------------------------------------------
// ex_result_skid_if
// Bundles the execute-stage result handshake of ex_result_skid.
//   Upstream side  : in_valid/in_ready plus the candidate results (sures,
//                    alu_res), the result select (res_sel), the writeback tags
//                    (rd_in, we_in) and the pipeline kill (flush).
//   Downstream side: out_valid/out_ready plus the head entry (out_res, out_rd,
//                    out_we).
// Modports:
//   slave  - the buffer itself (consumes the upstream side, drives the
//            downstream side).
//   master - the surrounding pipeline/bench (drives the upstream side and
//            out_ready, observes everything the buffer produces).
// ----------------------------------------------------------------------------
interface ex_result_skid_if #(
   parameter int N  = 32,
   parameter int RW = 5
);
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  sures;
   logic [N-1:0]  alu_res;
   logic          res_sel;
   logic [RW-1:0] rd_in;
   logic          we_in;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_res;
   logic [RW-1:0] out_rd;
   logic          out_we;

   modport slave (
      input  in_valid, sures, alu_res, res_sel, rd_in, we_in, flush, out_ready,
      output in_ready, out_valid, out_res, out_rd, out_we
   );

   modport master (
      output in_valid, sures, alu_res, res_sel, rd_in, we_in, flush, out_ready,
      input  in_ready, out_valid, out_res, out_rd, out_we
   );
endinterface

// File: rtl/ex_result_skid.sv
// ----------------------------------------------------------------------------
// ex_result_skid
// Execute-stage output buffer sitting directly after the shift unit and the
// ALU. Each accepted cycle it picks sures or alu_res (res_sel) and stores it
// with its writeback tags in a 2-entry skid buffer (head + skid), presenting
// the head to the EX/MEM boundary over valid/ready.
//   clk   - rising-edge clock
//   reset - synchronous, active-high; clears state and all entry registers
//   bus   - ex_result_skid_if.slave: upstream in_* / sures / alu_res /
//           res_sel / flush, downstream out_*
// Outputs are registered only: out_* come straight from the head register,
// in_ready and out_valid are decoded from the state register alone.
// ----------------------------------------------------------------------------
module ex_result_skid #(
   parameter int N  = 32,
   parameter int RW = 5
) (
   input  logic             clk,
   input  logic             reset,
   ex_result_skid_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  head_res_q, head_res_d;
   logic [RW-1:0] head_rd_q,  head_rd_d;
   logic          head_we_q,  head_we_d;
   logic [N-1:0]  skid_res_q, skid_res_d;
   logic [RW-1:0] skid_rd_q,  skid_rd_d;
   logic          skid_we_q,  skid_we_d;

   logic          accept;
   logic          pop;
   logic [N-1:0]  new_res;

   // Handshake outputs depend on state only, which keeps in_ready free of any
   // combinational path from out_ready.
   assign bus.in_ready  = (state_q != ST_FULL);
   assign bus.out_valid = (state_q != ST_EMPTY);
   assign bus.out_res   = head_res_q;
   assign bus.out_rd    = head_rd_q;
   assign bus.out_we    = head_we_q;

   assign accept  = bus.in_valid & bus.in_ready;
   assign pop     = bus.out_valid & bus.out_ready;
   assign new_res = bus.res_sel ? bus.sures : bus.alu_res;

   // NOTE: every always_comb output gets its hold value first so no path can
   // leave it unassigned; that is what keeps latches from being inferred.
   always_comb begin
      state_d    = state_q;
      head_res_d = head_res_q;
      head_rd_d  = head_rd_q;
      head_we_d  = head_we_q;
      skid_res_d = skid_res_q;
      skid_rd_d  = skid_rd_q;
      skid_we_d  = skid_we_q;

      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               head_res_d = new_res;
               head_rd_d  = bus.rd_in;
               head_we_d  = bus.we_in;
               state_d    = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && !pop) begin
               // Downstream stalled: park the newcomer behind the head.
               skid_res_d = new_res;
               skid_rd_d  = bus.rd_in;
               skid_we_d  = bus.we_in;
               state_d    = ST_FULL;
            end else if (accept && pop) begin
               // Head leaves this edge, newcomer takes its place directly.
               head_res_d = new_res;
               head_rd_d  = bus.rd_in;
               head_we_d  = bus.we_in;
            end else if (pop) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (pop) begin
               head_res_d = skid_res_q;
               head_rd_d  = skid_rd_q;
               head_we_d  = skid_we_q;
               state_d    = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      // A kill empties the buffer regardless of any same-cycle accept or pop;
      // the entry registers become don't-care once the state says EMPTY.
      if (bus.flush) begin
         state_d = ST_EMPTY;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values computed above, independent of block order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_EMPTY;
         // NOTE: the entry registers are cleared too, not only the state,
         // because out_res/out_rd/out_we must read as zero out of reset.
         head_res_q <= '0;
         head_rd_q  <= '0;
         head_we_q  <= 1'b0;
         skid_res_q <= '0;
         skid_rd_q  <= '0;
         skid_we_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         head_res_q <= head_res_d;
         head_rd_q  <= head_rd_d;
         head_we_q  <= head_we_d;
         skid_res_q <= skid_res_d;
         skid_rd_q  <= skid_rd_d;
         skid_we_q  <= skid_we_d;
      end
   end

endmodule

// File: tb/tb_ex_result_skid.sv
// ----------------------------------------------------------------------------
// tb_ex_result_skid
// Self-checking bench for ex_result_skid: a table of directed vectors with
// hand-derived expectations, hand-written back-to-back and mid-operation
// reset sequences, then randomized traffic compared every cycle against a
// queue-based model of a 2-deep FIFO with flush and reset.
// ----------------------------------------------------------------------------
module tb_ex_result_skid;

   localparam int N  = 32;
   localparam int RW = 5;

   logic clk;
   logic reset;

   ex_result_skid_if #(.N(N), .RW(RW)) bus ();

   ex_result_skid #(.N(N), .RW(RW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [N-1:0]  res;
      logic [RW-1:0] rd;
      logic          we;
   } entry_t;

   entry_t mq[$];   // reference FIFO contents, index 0 is the head

   typedef struct {
      logic          rst, fl, iv, rs;
      logic [N-1:0]  su, alu;
      logic [RW-1:0] rd;
      logic          we, ordy;
      logic          e_ov, e_ir, chk;
      logic [N-1:0]  e_res;
      logic [RW-1:0] e_rd;
      logic          e_we;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic fl, input logic iv, input logic rs,
                        input logic [N-1:0] su, input logic [N-1:0] alu,
                        input logic [RW-1:0] rd, input logic we, input logic ordy);
      reset         = rst;
      bus.flush     = fl;
      bus.in_valid  = iv;
      bus.res_sel   = rs;
      bus.sures     = su;
      bus.alu_res   = alu;
      bus.rd_in     = rd;
      bus.we_in     = we;
      bus.out_ready = ordy;
   endtask

   // Advance one clock edge, updating the model from the inputs held during
   // the cycle, then wait #1 so outputs are sampled clear of the edge.
   task automatic step();
      bit     acc, pp;
      entry_t e;
      acc   = bus.in_valid && (mq.size() < 2);
      pp    = bus.out_ready && (mq.size() > 0);
      e.res = bus.res_sel ? bus.sures : bus.alu_res;
      e.rd  = bus.rd_in;
      e.we  = bus.we_in;
      @(posedge clk);
      if (reset || bus.flush) begin
         mq.delete();
      end else begin
         if (pp)  void'(mq.pop_front());
         if (acc) mq.push_back(e);
      end
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".out_valid"}, N'(bus.out_valid), N'(mq.size() > 0));
      check({tag, ".in_ready"},  N'(bus.in_ready),  N'(mq.size() < 2));
      if (mq.size() > 0) begin
         check({tag, ".out_res"}, bus.out_res,     mq[0].res);
         check({tag, ".out_rd"},  N'(bus.out_rd),  N'(mq[0].rd));
         check({tag, ".out_we"},  N'(bus.out_we),  N'(mq[0].we));
      end
   endtask

   function automatic vec_t mk(logic rst, logic fl, logic iv, logic rs,
                               logic [N-1:0] su, logic [N-1:0] alu,
                               logic [RW-1:0] rd, logic we, logic ordy,
                               logic e_ov, logic e_ir, logic chk,
                               logic [N-1:0] e_res, logic [RW-1:0] e_rd, logic e_we);
      vec_t v;
      v.rst = rst; v.fl = fl; v.iv = iv; v.rs = rs; v.su = su; v.alu = alu;
      v.rd = rd; v.we = we; v.ordy = ordy; v.e_ov = e_ov; v.e_ir = e_ir;
      v.chk = chk; v.e_res = e_res; v.e_rd = e_rd; v.e_we = e_we;
      return v;
   endfunction

   initial begin
      drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);

      //                rst fl iv rs  sures         alu_res       rd  we ordy   ov ir chk res           rd  we
      // reset state
      vecs.push_back(mk(1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0,     0, 1, 1, 32'h0,        0, 0));
      // pass-through
      vecs.push_back(mk(0, 0, 1, 1, 32'h80808080, 32'h0,        9, 1, 1,     1, 1, 1, 32'h80808080, 9, 1));
      vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1,     0, 1, 0, 32'h0,        0, 0));
      // stall / skid, including an offer ignored while FULL
      vecs.push_back(mk(0, 0, 1, 0, 32'hDEADBEEF, 32'h11,       3, 0, 0,     1, 1, 1, 32'h11,       3, 0));
      vecs.push_back(mk(0, 0, 1, 1, 32'h02020202, 32'hCAFE,     4, 1, 0,     1, 0, 1, 32'h11,       3, 0));
      vecs.push_back(mk(0, 0, 1, 0, 32'h0,        32'h55,       7, 1, 0,     1, 0, 1, 32'h11,       3, 0));
      vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1,     1, 1, 1, 32'h02020202, 4, 1));
      vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1,     0, 1, 0, 32'h0,        0, 0));
      // flush with accept while FULL; flushed entry must never appear
      vecs.push_back(mk(0, 0, 1, 0, 32'h0,        32'h21,       1, 1, 0,     1, 1, 1, 32'h21,       1, 1));
      vecs.push_back(mk(0, 0, 1, 0, 32'h0,        32'h22,       2, 1, 0,     1, 0, 1, 32'h21,       1, 1));
      vecs.push_back(mk(0, 1, 1, 0, 32'h0,        32'h23,       3, 1, 1,     0, 1, 0, 32'h0,        0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 1,     0, 1, 0, 32'h0,        0, 0));
      // flush beats accept+pop while ONE
      vecs.push_back(mk(0, 0, 1, 0, 32'h0,        32'h31,       5, 0, 0,     1, 1, 1, 32'h31,       5, 0));
      vecs.push_back(mk(0, 1, 1, 1, 32'h32,       32'h0,        6, 1, 1,     0, 1, 0, 32'h0,        0, 0));
      // reset beats flush and clears the head registers
      vecs.push_back(mk(0, 0, 1, 1, 32'h41,       32'h0,        8, 1, 0,     1, 1, 1, 32'h41,       8, 1));
      vecs.push_back(mk(1, 1, 1, 0, 32'h0,        32'h42,       9, 1, 0,     0, 1, 1, 32'h0,        0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         drive(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].rs, vecs[i].su, vecs[i].alu,
               vecs[i].rd, vecs[i].we, vecs[i].ordy);
         step();
         check({tag, ".out_valid"}, N'(bus.out_valid), N'(vecs[i].e_ov));
         check({tag, ".in_ready"},  N'(bus.in_ready),  N'(vecs[i].e_ir));
         if (vecs[i].chk) begin
            check({tag, ".out_res"}, bus.out_res,    vecs[i].e_res);
            check({tag, ".out_rd"},  N'(bus.out_rd), N'(vecs[i].e_rd));
            check({tag, ".out_we"},  N'(bus.out_we), N'(vecs[i].e_we));
         end
      end

      // Back-to-back: 8 accepts with downstream always ready, both mux legs used.
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b0, 1'b1, i[0], (i[0] ? N'(i) : 32'hFFFF0000),
               (i[0] ? 32'h0000FFFF : N'(i)), RW'(i), i[1], 1'b1);
         step();
         check($sformatf("b2b%0d.out_valid", i), N'(bus.out_valid), 32'd1);
         check($sformatf("b2b%0d.out_res", i),   bus.out_res,       N'(i));
         check($sformatf("b2b%0d.in_ready", i),  N'(bus.in_ready),  32'd1);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
      step();
      check("b2b_drain.out_valid", N'(bus.out_valid), 32'd0);

      // Reset mid-operation while ONE, then a pass-through afterwards.
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h00020202, 32'h0, 5'd2, 1'b1, 1'b0);
      step();
      check("rstmid_pre.out_res", bus.out_res, 32'h00020202);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h77, 5'd3, 1'b1, 1'b0);
      step();
      check("rstmid.out_valid", N'(bus.out_valid), 32'd0);
      check("rstmid.out_res",   bus.out_res,       32'd0);
      check("rstmid.in_ready",  N'(bus.in_ready),  32'd1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h80808080, 32'h0, 5'd9, 1'b1, 1'b1);
      step();
      check("rstmid_pt.out_valid", N'(bus.out_valid), 32'd1);
      check("rstmid_pt.out_res",   bus.out_res,       32'h80808080);
      check("rstmid_pt.out_rd",    N'(bus.out_rd),    32'd9);
      check("rstmid_pt.out_we",    N'(bus.out_we),    32'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
      step();
      check("rstmid_pt2.out_valid", N'(bus.out_valid), 32'd0);

      // Randomized traffic against the model; occasional flush and reset.
      for (int c = 0; c < 1000; c++) begin
         drive(($urandom_range(0, 127) == 0), ($urandom_range(0, 31) == 0),
               1'($urandom), 1'($urandom), N'($urandom), N'($urandom),
               RW'($urandom), 1'($urandom), 1'($urandom));
         step();
         check_model($sformatf("rnd%0d", c));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
